ifu_xlat_fetch: RTL and testbench
=================================

Name: ifu_xlat_fetch

Overview:
- Parametrised next-generation instruction fetch unit. Owns the fetch PC and runs one instruction fetch at a time: optional SV32 translation request/response, then a physical memory read.
- Fetched instructions, with their trap bits, go into a DEPTH-entry fetch queue that feeds IF/ID over a valid/ready handshake.
- Adds what the previous IFU lacked: real request/response handshakes, a fetch queue, flush with drop of in-flight responses, misaligned and access-fault traps, and a halt after a fault.

Parameters:
- ADDR_W, 32, width of virtual/physical PC and addresses
- INST_W, 32, instruction word width
- FQ_DEPTH, 4, fetch queue entries; power of two, at least 2
- TRAP_LEN, 16, width of trap bus
- TRAP_MISALIGN_BIT, 0, trap bit index for instruction address misaligned
- TRAP_ACCESS_BIT, 1, trap bit index for instruction access fault
- TRAP_PAGE_BIT, 12, trap bit index for instruction page fault
- RESET_PC, 32'h8000_0000, fetch PC after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect_valid_i  in  1  flush everything and restart fetch at redirect_pc_i
- redirect_pc_i  in  ADDR_W  new fetch PC
- mmu_enable_i  in  1  1 = translate; 0 = physical address equals virtual address
- xlat_req_valid_o  out  1  translation request
- xlat_req_vaddr_o  out  ADDR_W  virtual PC
- xlat_req_ready_i  in  1  MMU accepts the request
- xlat_resp_valid_i  in  1  translation result valid
- xlat_resp_paddr_i  in  ADDR_W  physical address
- xlat_resp_fault_i  in  1  page fault
- mem_req_valid_o  out  1  instruction read request
- mem_req_addr_o  out  ADDR_W  physical address
- mem_req_ready_i  in  1  memory accepts the request
- mem_resp_valid_i  in  1  read data valid
- mem_resp_data_i  in  INST_W  instruction word
- mem_resp_err_i  in  1  bus error
- out_valid_o  out  1  queue head valid
- out_ready_i  in  1  IF/ID consumes the head
- out_pc_o  out  ADDR_W  PC of the head entry
- out_inst_o  out  INST_W  instruction of the head entry; 0 if it carries a trap
- out_trap_o  out  TRAP_LEN  trap bits of the head entry
- fq_empty_stall_o  out  1  queue empty; pipeline stall request

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=RESET_PC, queue empty, occupancy count 0.
  - All *_valid_o=0, fq_empty_stall_o=1, data outputs 0.
- States: IDLE, XLAT_REQ, XLAT_WAIT, MEM_REQ, MEM_WAIT, DRAIN, HALT.
- IDLE
  - Waits while the queue is full.
  - If pc[1:0]!=0: enqueue a misaligned-trap entry, go to HALT.
  - Otherwise go to XLAT_REQ if mmu_enable_i=1, else to MEM_REQ with paddr=pc.
- XLAT_REQ
  - Asserts xlat_req_valid_o; vaddr is held stable until xlat_req_ready_i.
  - Handshake completes → XLAT_WAIT.
- XLAT_WAIT, on xlat_resp_valid_i:
  - fault=1: enqueue a page-fault entry, go to HALT.
  - fault=0: latch paddr, go to MEM_REQ.
- MEM_REQ
  - Asserts mem_req_valid_o; address is held stable until mem_req_ready_i.
  - Handshake completes → MEM_WAIT.
- MEM_WAIT, on mem_resp_valid_i:
  - err=1: enqueue an access-fault entry, go to HALT.
  - err=0: enqueue {pc, data, 0}, pc<=pc+4 (wraps modulo 2^ADDR_W), go to IDLE.
- HALT: no new fetches until redirect. Guarantees a single trap entry per fault.
- Minimum latency with single-cycle ready and response, mmu off: request 1 cycle after IDLE, entry visible the cycle after the response. Minimum IDLE to out_valid_o is 3 cycles.
- A trap entry sets exactly one trap bit and has out_inst_o=0.
- Redirect (highest priority, any state):
  - Queue is cleared the same edge and pc<=redirect_pc_i.
  - From XLAT_WAIT or MEM_WAIT → DRAIN.
  - From XLAT_REQ or MEM_REQ the valid is withdrawn only after its handshake completes; that request's response is dropped via DRAIN.
  - All other states → IDLE.
- DRAIN
  - Discards exactly one pending response, which may arrive in the same cycle as the redirect, then goes to IDLE.
  - A second redirect in DRAIN only updates pc.
- Queue
  - Circular buffer; pointers wrap at FQ_DEPTH.
  - Enqueue and dequeue in the same cycle when full is legal; occupancy unchanged.
  - Redirect wins over a same-cycle enqueue or dequeue.
- Outputs
  - out_* come from registered storage; no combinational path from out_ready_i to out_valid_o.
  - fq_empty_stall_o = (count==0).
- Translation is re-requested for every fetch (no local caching). mmu_enable_i is sampled only in IDLE.

Test Plan:
- Reset, then release with mmu off, single-cycle ready/response, data 0x00000013 at every address → entries pc=0x80000000, 0x80000004, 0x80000008 in order; first out_valid_o 3 cycles after IDLE.
- Hold out_ready_i=0 with FQ_DEPTH=4 → exactly 4 entries, no mem_req_valid_o while full. Pop one → exactly one new fetch, pc=0x80000010.
- mmu on, vaddr 0x80000000 translates to paddr 0x00201000 → mem_req_addr_o=0x00201000, out_pc_o=0x80000000. Next vaddr returns fault=1 → out_trap_o bit 12 set, inst 0, no further requests until redirect.
- Redirect to 0x80000100 during MEM_WAIT; stale response 0xDEADBEEF arrives 2 cycles later → dropped, queue empty, next fetch from 0x80000100.
- Redirect to 0x80000102 → misaligned entry (bit 0) with no memory request. mem_resp_err_i=1 on a normal fetch → access-fault entry (bit 1).
- Assert rst_n low while in MEM_WAIT with 3 entries queued → immediately out_valid_o=0, queue empty; after release, fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ifu_xlat_fetch.sv
// ifu_xlat_fetch: one-at-a-time instruction fetch with optional translation, trap
// generation and a circular fetch queue feeding IF/ID.
module ifu_xlat_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int FQ_DEPTH = 4,
    parameter int TRAP_LEN = 16,
    parameter int TRAP_MISALIGN_BIT = 0,
    parameter int TRAP_ACCESS_BIT = 1,
    parameter int TRAP_PAGE_BIT = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    input  logic                mmu_enable_i,
    output logic                xlat_req_valid_o,
    output logic [ADDR_W-1:0]   xlat_req_vaddr_o,
    input  logic                xlat_req_ready_i,
    input  logic                xlat_resp_valid_i,
    input  logic [ADDR_W-1:0]   xlat_resp_paddr_i,
    input  logic                xlat_resp_fault_i,
    output logic                mem_req_valid_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    input  logic                mem_req_ready_i,
    input  logic                mem_resp_valid_i,
    input  logic [INST_W-1:0]   mem_resp_data_i,
    input  logic                mem_resp_err_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ADDR_W-1:0]   out_pc_o,
    output logic [INST_W-1:0]   out_inst_o,
    output logic [TRAP_LEN-1:0] out_trap_o,
    output logic                fq_empty_stall_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XREQ  = 3'd1;
    localparam logic [2:0] S_XWAIT = 3'd2;
    localparam logic [2:0] S_MREQ  = 3'd3;
    localparam logic [2:0] S_MWAIT = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]          state, nxt;
    logic [ADDR_W-1:0]   pc, addr, addr_nxt;
    logic                kill, kill_nxt, drain_mem, drain_mem_nxt;
    logic [PW-1:0]       rd, wr;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-1:0]   pc_q [FQ_DEPTH];
    logic [INST_W-1:0]   inst_q [FQ_DEPTH];
    logic [TRAP_LEN-1:0] trap_q [FQ_DEPTH];
    logic                enq, inc, deq, full, wr_en;
    logic [INST_W-1:0]   enq_inst;
    logic [TRAP_LEN-1:0] enq_trap;

    assign full  = cnt == CW'(FQ_DEPTH);
    assign deq   = out_ready_i && cnt != '0;
    assign wr_en = enq && !redirect_valid_i;

    always_comb begin
        nxt = state;
        enq = 1'b0;
        enq_inst = '0;
        enq_trap = '0;
        inc = 1'b0;
        kill_nxt = kill;
        drain_mem_nxt = drain_mem;
        addr_nxt = addr;
        case (state)
            S_IDLE: if (!full) begin
                if (pc[1:0] != 2'b00) begin
                    enq = 1'b1;
                    enq_trap[TRAP_MISALIGN_BIT] = 1'b1;
                    nxt = S_HALT;
                end else begin
                    addr_nxt = pc;
                    nxt = mmu_enable_i ? S_XREQ : S_MREQ;
                end
            end
            // a request hit by a redirect stays up until accepted, then its response is drained
            S_XREQ: if (xlat_req_ready_i) begin
                nxt = (kill || redirect_valid_i) ? S_DRAIN : S_XWAIT;
                kill_nxt = 1'b0;
                drain_mem_nxt = 1'b0;
            end else if (redirect_valid_i) kill_nxt = 1'b1;
            S_XWAIT: if (xlat_resp_valid_i) begin
                if (xlat_resp_fault_i) begin
                    enq = 1'b1;
                    enq_trap[TRAP_PAGE_BIT] = 1'b1;
                    nxt = S_HALT;
                end else begin
                    addr_nxt = xlat_resp_paddr_i;
                    nxt = S_MREQ;
                end
            end
            S_MREQ: if (mem_req_ready_i) begin
                nxt = (kill || redirect_valid_i) ? S_DRAIN : S_MWAIT;
                kill_nxt = 1'b0;
                drain_mem_nxt = 1'b1;
            end else if (redirect_valid_i) kill_nxt = 1'b1;
            S_MWAIT: if (mem_resp_valid_i) begin
                enq = 1'b1;
                if (mem_resp_err_i) begin
                    enq_trap[TRAP_ACCESS_BIT] = 1'b1;
                    nxt = S_HALT;
                end else begin
                    enq_inst = mem_resp_data_i;
                    inc = 1'b1;
                    nxt = S_IDLE;
                end
            end
            S_DRAIN: if (drain_mem ? mem_resp_valid_i : xlat_resp_valid_i) nxt = S_IDLE;
            default: ;
        endcase
        if (redirect_valid_i) begin
            if (state == S_XWAIT || state == S_MWAIT) begin
                nxt = ((state == S_XWAIT) ? xlat_resp_valid_i : mem_resp_valid_i) ? S_IDLE : S_DRAIN;
                drain_mem_nxt = state == S_MWAIT;
            end else if (state == S_IDLE || state == S_HALT) nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc <= RESET_PC;
            addr <= '0;
            kill <= 1'b0;
            drain_mem <= 1'b0;
            rd <= '0;
            wr <= '0;
            cnt <= '0;
        end else begin
            state <= nxt;
            addr <= addr_nxt;
            kill <= kill_nxt;
            drain_mem <= drain_mem_nxt;
            if (redirect_valid_i) begin
                pc <= redirect_pc_i;
                rd <= '0;
                wr <= '0;
                cnt <= '0;
            end else begin
                if (inc) pc <= pc + ADDR_W'(4);
                if (enq) wr <= wr + PW'(1);
                if (deq) rd <= rd + PW'(1);
                cnt <= cnt + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_q[wr] <= pc;
            inst_q[wr] <= enq_inst;
            trap_q[wr] <= enq_trap;
        end
    end

    assign out_valid_o      = cnt != '0;
    assign out_pc_o         = out_valid_o ? pc_q[rd] : '0;
    assign out_inst_o       = out_valid_o ? inst_q[rd] : '0;
    assign out_trap_o       = out_valid_o ? trap_q[rd] : '0;
    assign fq_empty_stall_o = cnt == '0;
    assign xlat_req_valid_o = state == S_XREQ;
    assign mem_req_valid_o  = state == S_MREQ;
    assign xlat_req_vaddr_o = addr;
    assign mem_req_addr_o   = addr;
endmodule

// File: tb/tb_ifu_xlat_fetch.sv
// tb_ifu_xlat_fetch: randomized MMU/memory responders plus an expected-instruction-stream
// model; directed phases pin latency, fill, translation, flush, trap and reset behaviour.
module tb_ifu_xlat_fetch;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid_i = 1'b0, mmu_enable_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        xlat_req_valid_o, xlat_req_ready_i = 1'b0, xlat_resp_valid_i = 1'b0, xlat_resp_fault_i = 1'b0;
    logic [31:0] xlat_req_vaddr_o, xlat_resp_paddr_i = '0;
    logic        mem_req_valid_o, mem_req_ready_i = 1'b0, mem_resp_valid_i = 1'b0, mem_resp_err_i = 1'b0;
    logic [31:0] mem_req_addr_o, mem_resp_data_i = '0;
    logic        out_valid_o, out_ready_i = 1'b0, fq_empty_stall_o;
    logic [31:0] out_pc_o, out_inst_o;
    logic [15:0] out_trap_o;

    always #5 clk = ~clk;

    ifu_xlat_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .mmu_enable_i(mmu_enable_i),
        .xlat_req_valid_o(xlat_req_valid_o), .xlat_req_vaddr_o(xlat_req_vaddr_o), .xlat_req_ready_i(xlat_req_ready_i),
        .xlat_resp_valid_i(xlat_resp_valid_i), .xlat_resp_paddr_i(xlat_resp_paddr_i), .xlat_resp_fault_i(xlat_resp_fault_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
        .out_trap_o(out_trap_o), .fq_empty_stall_o(fq_empty_stall_o)
    );

    int n_chk = 0, n_fail = 0;
    int rdy_pct = 100, min_dly = 0, max_dly = 0, pop_pct = 0, redir_pct = 0;
    bit fixed13 = 1'b1, bad_data = 1'b0, rd_req = 1'b0, rd_mmu = 1'b0;
    logic [31:0] rd_pc = '0;
    logic [31:0] m_pc = 32'h8000_0000;
    bit m_mmu = 1'b0, m_halt = 1'b0;
    logic [31:0] last_pc = '0, last_inst = '0, last_mem_addr = '0;
    logic [15:0] last_trap = '0;
    int pops = 0, mem_acc = 0;
    bit xp = 1'b0, mp = 1'b0, mp_bad = 1'b0;
    int xc = 0, mc = 0;
    logic [31:0] xa = '0, ma = '0;
    bit pxv = 1'b0, pxa = 1'b0, pmv = 1'b0, pma = 1'b0;
    logic [31:0] pva = '0, pmadr = '0;

    function automatic logic [31:0] xl(input logic [31:0] v);
        return ((v + 32'h1000) & 32'h003F_FFFF) | 32'h0020_0000;
    endfunction
    function automatic bit pf(input logic [31:0] v);
        return v[6:2] == 5'h01;
    endfunction
    function automatic bit be(input logic [31:0] p);
        return p[7:2] == 6'h1D;
    endfunction
    function automatic logic [31:0] dat(input logic [31:0] p);
        return fixed13 ? 32'h0000_0013 : (p ^ 32'h1234_5678);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait budget expired", nm);
    endtask

    // Expected stream: consecutive words from the last redirect/reset PC, ending at the first trap.
    task automatic pop_check();
        logic [31:0] ei, p;
        logic [15:0] et;
        pops++;
        last_pc = out_pc_o;
        last_inst = out_inst_o;
        last_trap = out_trap_o;
        if (m_halt) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_entry: got pc %h after a trap, required no entry", out_pc_o);
            return;
        end
        ei = '0;
        et = '0;
        if (m_pc[1:0] != 2'b00) et[0] = 1'b1;
        else if (m_mmu && pf(m_pc)) et[12] = 1'b1;
        else begin
            p = m_mmu ? xl(m_pc) : m_pc;
            if (be(p)) et[1] = 1'b1;
            else ei = dat(p);
        end
        chk("out_pc", out_pc_o, m_pc);
        chk("out_inst", out_inst_o, ei);
        chk("out_trap", 32'(out_trap_o), 32'(et));
        if (et != '0) m_halt = 1'b1;
        else m_pc = m_pc + 32'd4;
    endtask

    task automatic step();
        @(negedge clk);
        chk("stall_vs_valid", 32'(fq_empty_stall_o), 32'(!out_valid_o));
        if (pxv && !pxa) begin
            chk("xreq_hold_valid", 32'(xlat_req_valid_o), 32'd1);
            chk("xreq_hold_addr", xlat_req_vaddr_o, pva);
        end
        if (pmv && !pma) begin
            chk("mreq_hold_valid", 32'(mem_req_valid_o), 32'd1);
            chk("mreq_hold_addr", mem_req_addr_o, pmadr);
        end
        if (m_halt) chk("halt_no_req", 32'(xlat_req_valid_o | mem_req_valid_o), 32'd0);
        out_ready_i = $urandom_range(99) < pop_pct;
        if (out_valid_o && out_ready_i) pop_check();
        redirect_valid_i = rd_req || (redir_pct > 0 &&
            ($urandom_range(99) < redir_pct || (m_halt && $urandom_range(3) == 0)));
        if (redirect_valid_i) begin
            if (rd_req) begin
                redirect_pc_i = rd_pc;
                m_mmu = rd_mmu;
            end else begin
                redirect_pc_i = ($urandom_range(15) == 0) ? 32'hFFFF_FFF8 :
                    32'h8000_0000 + 32'($urandom_range(63)) * 4 +
                    (($urandom_range(7) == 0) ? 32'($urandom_range(3)) : 32'd0);
                m_mmu = $urandom_range(1) == 1;
            end
            m_pc = redirect_pc_i;
            m_halt = 1'b0;
            rd_req = 1'b0;
        end else redirect_pc_i = $urandom;
        mmu_enable_i = m_mmu;
        xlat_resp_valid_i = 1'b0;
        xlat_resp_paddr_i = $urandom;
        xlat_resp_fault_i = $urandom_range(1) == 1;
        if (xp) begin
            if (xc == 0) begin
                xlat_resp_valid_i = 1'b1;
                xlat_resp_paddr_i = xl(xa);
                xlat_resp_fault_i = pf(xa);
                xp = 1'b0;
            end else xc--;
        end
        xlat_req_ready_i = $urandom_range(99) < rdy_pct;
        if (xlat_req_valid_o && xlat_req_ready_i) begin
            xp = 1'b1;
            xc = $urandom_range(max_dly, min_dly);
            xa = xlat_req_vaddr_o;
        end
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = $urandom;
        mem_resp_err_i = $urandom_range(1) == 1;
        if (mp) begin
            if (mc == 0) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i = mp_bad ? 32'hDEAD_BEEF : dat(ma);
                mem_resp_err_i = mp_bad ? 1'b0 : be(ma);
                mp = 1'b0;
            end else mc--;
        end
        mem_req_ready_i = $urandom_range(99) < rdy_pct;
        if (mem_req_valid_o && mem_req_ready_i) begin
            mp = 1'b1;
            mc = $urandom_range(max_dly, min_dly);
            ma = mem_req_addr_o;
            mp_bad = bad_data;
            mem_acc++;
            last_mem_addr = mem_req_addr_o;
        end
        pxv = xlat_req_valid_o;
        pxa = xlat_req_valid_o && xlat_req_ready_i;
        pva = xlat_req_vaddr_o;
        pmv = mem_req_valid_o;
        pma = mem_req_valid_o && mem_req_ready_i;
        pmadr = mem_req_addr_o;
    endtask

    task automatic wait_pops(input int target, input string nm);
        int k = 0;
        while (pops < target && k < 100) begin step(); k++; end
        if (pops < target) timeout(nm);
    endtask

    task automatic wait_acc(input int target, input string nm);
        int k = 0;
        while (mem_acc < target && k < 100) begin step(); k++; end
        if (mem_acc < target) timeout(nm);
    endtask

    task automatic redirect_to(input logic [31:0] pc, input bit mmu);
        rd_req = 1'b1;
        rd_pc = pc;
        rd_mmu = mmu;
        step();
    endtask

    initial begin
        int n, base;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_stall", 32'(fq_empty_stall_o), 32'd1);
        chk("rst_xreq", 32'(xlat_req_valid_o), 32'd0);
        chk("rst_mreq", 32'(mem_req_valid_o), 32'd0);
        chk("rst_out_pc", out_pc_o, 32'd0);
        chk("rst_out_inst", out_inst_o, 32'd0);
        chk("rst_out_trap", 32'(out_trap_o), 32'd0);
        chk("rst_vaddr", xlat_req_vaddr_o, 32'd0);
        chk("rst_maddr", mem_req_addr_o, 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!out_valid_o && n < 20);
        chk("first_valid_latency", n, 32'd3);
        repeat (9) step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_req_when_full", 32'(mem_req_valid_o), 32'd0);
        end
        chk("fill_count", mem_acc, 32'd4);
        pop_pct = 100;
        step();
        pop_pct = 0;
        chk("pop0_pc", last_pc, 32'h8000_0000);
        chk("pop0_inst", last_inst, 32'h0000_0013);
        repeat (6) step();
        chk("refill_count", mem_acc, 32'd5);
        chk("refill_addr", last_mem_addr, 32'h8000_0010);

        pop_pct = 100;
        redirect_to(32'h8000_0000, 1'b1);
        base = pops;
        wait_pops(base + 1, "mmu_first");
        chk("mmu_pc", last_pc, 32'h8000_0000);
        chk("mmu_inst", last_inst, 32'h0000_0013);
        wait_pops(base + 2, "mmu_fault");
        chk("pf_pc", last_pc, 32'h8000_0004);
        chk("pf_trap", 32'(last_trap), 32'h0000_1000);
        chk("pf_inst", last_inst, 32'd0);
        chk("mmu_paddr", last_mem_addr, 32'h0020_1000);
        repeat (5) step();
        chk("pf_halt_xreq", 32'(xlat_req_valid_o), 32'd0);

        pop_pct = 0;
        min_dly = 2;
        max_dly = 2;
        bad_data = 1'b1;
        redirect_to(32'h8000_0000, 1'b0);
        wait_acc(mem_acc + 1, "stale_req");
        bad_data = 1'b0;
        min_dly = 0;
        max_dly = 0;
        redirect_to(32'h8000_0100, 1'b0);
        repeat (3) step();
        chk("stale_dropped_empty", 32'(fq_empty_stall_o), 32'd1);
        wait_acc(mem_acc + 1, "after_stale_req");
        chk("after_stale_addr", last_mem_addr, 32'h8000_0100);
        pop_pct = 100;
        base = pops;
        wait_pops(base + 1, "after_stale_pop");
        chk("after_stale_pc", last_pc, 32'h8000_0100);

        redirect_to(32'h8000_0102, 1'b0);
        base = pops;
        n = mem_acc;
        wait_pops(base + 1, "misalign");
        repeat (3) step();
        chk("mis_trap", 32'(last_trap), 32'h0000_0001);
        chk("mis_pc", last_pc, 32'h8000_0102);
        chk("mis_inst", last_inst, 32'd0);
        chk("mis_no_mem", mem_acc, n);
        redirect_to(32'h8000_0074, 1'b0);
        base = pops;
        wait_pops(base + 1, "access_fault");
        chk("af_trap", 32'(last_trap), 32'h0000_0002);
        chk("af_pc", last_pc, 32'h8000_0074);
        chk("af_inst", last_inst, 32'd0);

        pop_pct = 0;
        redirect_to(32'h8000_0200, 1'b0);
        wait_acc(mem_acc + 4, "fill3");
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid_o), 32'd0);
        chk("async_rst_stall", 32'(fq_empty_stall_o), 32'd1);
        redirect_valid_i = 1'b0;
        xlat_resp_valid_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        xp = 1'b0;
        mp = 1'b0;
        pxv = 1'b0;
        pmv = 1'b0;
        m_pc = 32'h8000_0000;
        m_mmu = 1'b0;
        m_halt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pop_pct = 100;
        base = pops;
        wait_pops(base + 1, "post_reset");
        chk("post_reset_pc", last_pc, 32'h8000_0000);

        fixed13 = 1'b0;
        rdy_pct = 60;
        max_dly = 2;
        pop_pct = 60;
        redir_pct = 3;
        redirect_to(32'h8000_0000, 1'b0);
        repeat (4000) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
